// File: rtl/tmds_decoder.sv
// TMDS receive channel: serial-to-word alignment from control tokens, data/control decode, illegal-symbol flagging.
// Optional saturating sym_err counter on port err_count when TMDS_DEC_ERRCNT_EN is defined.
module tmds_decoder #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  output logic [9:0] raw_word,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de,
  output logic       word_valid,
  output logic       locked,
  output logic       sym_err
`ifdef TMDS_DEC_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  localparam logic [3:0] LOCK_LIM   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_CNT);

  logic [9:0] r_sh;
  logic [1:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_tok_cnt;
  logic [3:0] r_err_run;
  logic [9:0] r_raw_word;
  logic [7:0] r_data;
  logic [1:0] r_ctrl;
  logic       r_de;
  logic       r_word_valid;
  logic       r_sym_err;

  logic [9:0] w_win;
  logic       w_is_tok;
  logic [1:0] w_tok_code;
  logic [6:0] w_tr;
  logic [3:0] w_tr_cnt;
  logic       w_illegal;
  logic [7:0] w_d;
  logic [7:0] w_dec;
  logic       w_at_end;
  logic [3:0] w_tok_inc;
  logic [3:0] w_err_inc;
  logic       w_drop;
  logic       w_emit;

  // The window includes the bit arriving this cycle, so a word is judged on the edge that samples its last bit.
  assign w_win = {serial_in, r_sh[9:1]};

  always_comb begin
    w_is_tok   = 1'b1;
    w_tok_code = 2'b00;
    case (w_win)
      TOK_00:  w_tok_code = 2'b00;
      TOK_01:  w_tok_code = 2'b01;
      TOK_10:  w_tok_code = 2'b10;
      TOK_11:  w_tok_code = 2'b11;
      default: w_is_tok   = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_tr
      assign w_tr[gi] = w_win[gi] ^ w_win[gi+1];
    end
  endgenerate

  always_comb begin
    w_tr_cnt = 4'd0;
    for (int i = 0; i < 7; i++) w_tr_cnt = w_tr_cnt + {3'b000, w_tr[i]};
  end

  assign w_illegal = !w_is_tok && (w_tr_cnt > 4'd4);

  assign w_d      = w_win[9] ? ~w_win[7:0] : w_win[7:0];
  assign w_dec[0] = w_d[0];
  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign w_dec[gi] = w_win[8] ? (w_d[gi] ^ w_d[gi-1]) : ~(w_d[gi] ^ w_d[gi-1]);
    end
  endgenerate

  assign w_at_end  = (r_bit_cnt == 4'd9);
  assign w_tok_inc = (r_tok_cnt == 4'hF) ? r_tok_cnt : r_tok_cnt + 4'd1;
  assign w_err_inc = (r_err_run == 4'hF) ? r_err_run : r_err_run + 4'd1;
  assign w_drop    = (r_state == S_LOCKED) && w_at_end && w_illegal && (w_err_inc >= UNLOCK_LIM);
  assign w_emit    = (r_state == S_LOCKED) && w_at_end && !w_drop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sh      <= '0;
      r_state   <= S_HUNT;
      r_bit_cnt <= '0;
      r_tok_cnt <= '0;
      r_err_run <= '0;
    end else begin
      r_sh <= w_win;
      case (r_state)
        S_HUNT: begin
          if (w_is_tok) begin
            r_bit_cnt <= '0;
            r_tok_cnt <= 4'd1;
            r_state   <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          r_bit_cnt <= w_at_end ? 4'd0 : r_bit_cnt + 4'd1;
          if (w_at_end) begin
            if (w_is_tok) begin
              r_tok_cnt <= w_tok_inc;
              if (w_tok_inc >= LOCK_LIM) begin
                r_state   <= S_LOCKED;
                r_err_run <= '0;
              end
            end else begin
              r_tok_cnt <= '0;
              r_state   <= S_HUNT;
            end
          end
        end
        S_LOCKED: begin
          r_bit_cnt <= w_at_end ? 4'd0 : r_bit_cnt + 4'd1;
          if (w_drop) begin
            r_state   <= S_HUNT;
            r_tok_cnt <= '0;
            r_err_run <= '0;
          end else if (w_at_end) begin
            r_err_run <= w_illegal ? w_err_inc : 4'd0;
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  // Data and control fields each hold their last value while the other kind of word is received.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_raw_word   <= '0;
      r_data       <= '0;
      r_ctrl       <= '0;
      r_de         <= 1'b0;
      r_word_valid <= 1'b0;
      r_sym_err    <= 1'b0;
    end else begin
      r_word_valid <= w_emit;
      r_sym_err    <= w_emit && w_illegal;
      if (w_emit) begin
        r_raw_word <= w_win;
        r_de       <= !w_is_tok;
        if (w_is_tok) r_ctrl <= w_tok_code;
        else          r_data <= w_dec;
      end
    end
  end

`ifdef TMDS_DEC_ERRCNT_EN
  logic [15:0] r_err_count;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                                r_err_count <= '0;
    else if (w_emit && w_illegal && r_err_count != 16'hFFFF)   r_err_count <= r_err_count + 16'd1;
  end
  assign err_count = r_err_count;
`endif

  assign raw_word   = r_raw_word;
  assign data_out   = r_data;
  assign ctrl_out   = r_ctrl;
  assign de         = r_de;
  assign word_valid = r_word_valid;
  assign sym_err    = r_sym_err;
  assign locked     = (r_state == S_LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: alignment, decode, error-driven unlock, bit slip and async reset.
module tb_tmds_decoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] BAD   = 10'h155;

  logic       clk;
  logic       n_rst;
  logic       serial_in;
  logic [9:0] raw_word;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de;
  logic       word_valid;
  logic       locked;
  logic       sym_err;
`ifdef TMDS_DEC_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int wv_cnt;
  int se_cnt;

  tmds_decoder dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .serial_in  (serial_in),
    .raw_word   (raw_word),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .de         (de),
    .word_valid (word_valid),
    .locked     (locked),
    .sym_err    (sym_err)
`ifdef TMDS_DEC_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
    if (word_valid) wv_cnt++;
    if (sym_err)    se_cnt++;
  endtask

  task automatic send_bits(input logic [9:0] w, input int n);
    wv_cnt = 0;
    se_cnt = 0;
    for (int i = 0; i < n; i++) send_bit(w[i]);
    $display("[TB] word %03h bits=%0d wv=%0d se=%0d de=%b data=%02h ctrl=%0d locked=%b",
             w, n, wv_cnt, se_cnt, de, data_out, ctrl_out, locked);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (locked !== 1'b0)      begin tests_failed++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests_run++; if (word_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_wv: got %b want 0", word_valid); end
    tests_run++; if (raw_word !== 10'h000) begin tests_failed++; $display("FAIL reset_raw: got %h want 000", raw_word); end
    tests_run++; if (data_out !== 8'h00)   begin tests_failed++; $display("FAIL reset_data: got %h want 00", data_out); end
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (locked !== 1'b0)      begin tests_failed++; $display("FAIL reset_release_locked: got %b want 0", locked); end
  endtask

  task automatic test_lock;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_bits(TOK00, 10);
      tests_run++; if (locked !== (k == 3)) begin tests_failed++; $display("FAIL lock_tok%0d: locked got %b want %b", k, locked, k == 3); end
      tests_run++; if (wv_cnt != 0) begin tests_failed++; $display("FAIL lock_nowv%0d: strobes got %0d want 0", k, wv_cnt); end
    end
    send_bits(TOK00, 10);
    tests_run++; if (wv_cnt != 1 || word_valid !== 1'b1) begin tests_failed++; $display("FAIL first_word_wv: strobes %0d now %b want 1/1", wv_cnt, word_valid); end
    tests_run++; if (de !== 1'b0)      begin tests_failed++; $display("FAIL first_word_de: got %b want 0", de); end
    tests_run++; if (ctrl_out !== 2'b00) begin tests_failed++; $display("FAIL first_word_ctrl: got %b want 00", ctrl_out); end
    tests_run++; if (raw_word !== TOK00) begin tests_failed++; $display("FAIL first_word_raw: got %h want %h", raw_word, TOK00); end
  endtask

  task automatic test_data;
    logic [9:0] words [4] = '{10'h100, 10'h200, 10'h101, 10'h001};
    logic [7:0] exp   [4] = '{8'h00, 8'hFF, 8'h03, 8'hFD};
    for (int k = 0; k < 4; k++) begin
      send_bits(words[k], 10);
      tests_run++; if (wv_cnt != 1 || de !== 1'b1 || sym_err !== 1'b0) begin tests_failed++; $display("FAIL data%0d_flags: wv=%0d de=%b se=%b want 1/1/0", k, wv_cnt, de, sym_err); end
      tests_run++; if (data_out !== exp[k]) begin tests_failed++; $display("FAIL data%0d_value: got %h want %h", k, data_out, exp[k]); end
      tests_run++; if (ctrl_out !== 2'b00) begin tests_failed++; $display("FAIL data%0d_ctrl_hold: got %b want 00", k, ctrl_out); end
    end
  endtask

  task automatic test_ctrl;
    logic [9:0] toks [3] = '{TOK01, TOK10, TOK11};
    logic [1:0] exp  [3] = '{2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) begin
      send_bits(toks[k], 10);
      tests_run++; if (wv_cnt != 1 || de !== 1'b0 || se_cnt != 0) begin tests_failed++; $display("FAIL ctrl%0d_flags: wv=%0d de=%b se=%0d want 1/0/0", k, wv_cnt, de, se_cnt); end
      tests_run++; if (ctrl_out !== exp[k]) begin tests_failed++; $display("FAIL ctrl%0d_value: got %b want %b", k, ctrl_out, exp[k]); end
      tests_run++; if (data_out !== 8'hFD) begin tests_failed++; $display("FAIL ctrl%0d_data_hold: got %h want FD", k, data_out); end
    end
  endtask

  task automatic test_errors;
    int se_total = 0;
    for (int k = 0; k < 7; k++) begin send_bits(BAD, 10); se_total += se_cnt; end
    tests_run++; if (se_total != 7) begin tests_failed++; $display("FAIL err7_count: got %0d want 7", se_total); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL err7_locked: got %b want 1", locked); end
    tests_run++; if (data_out !== 8'hFF || de !== 1'b1) begin tests_failed++; $display("FAIL err7_decode: data=%h de=%b want FF/1", data_out, de); end
    send_bits(TOK00, 10);
    tests_run++; if (wv_cnt != 1 || se_cnt != 0 || ctrl_out !== 2'b00) begin tests_failed++; $display("FAIL err_legal: wv=%0d se=%0d ctrl=%b want 1/0/00", wv_cnt, se_cnt, ctrl_out); end
    se_total = 0;
    for (int k = 0; k < 7; k++) begin send_bits(BAD, 10); se_total += se_cnt; end
    tests_run++; if (se_total != 7 || locked !== 1'b1) begin tests_failed++; $display("FAIL err_run7: se=%0d locked=%b want 7/1", se_total, locked); end
    send_bits(BAD, 10);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL err_drop_locked: got %b want 0", locked); end
    tests_run++; if (wv_cnt != 0 || se_cnt != 0) begin tests_failed++; $display("FAIL err_drop_strobe: wv=%0d se=%0d want 0/0", wv_cnt, se_cnt); end
    for (int k = 0; k < 4; k++) send_bits(TOK00, 10);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL err_relock: got %b want 1", locked); end
  endtask

  task automatic test_slip;
    int se_total = 0;
    int wv_total = 0;
    send_bits(TOK00, 10);
    tests_run++; if (wv_cnt != 1 || de !== 1'b0) begin tests_failed++; $display("FAIL slip_pre: wv=%0d de=%b want 1/0", wv_cnt, de); end
    send_bits(TOK00 >> 1, 9);
    wv_total += wv_cnt;
    for (int k = 0; k < 7; k++) begin send_bits(TOK00, 10); se_total += se_cnt; wv_total += wv_cnt; end
    tests_run++; if (se_total != 7 || wv_total != 7) begin tests_failed++; $display("FAIL slip_errs: se=%0d wv=%0d want 7/7", se_total, wv_total); end
    tests_run++; if (raw_word !== 10'h1AA || data_out !== 8'hFE) begin tests_failed++; $display("FAIL slip_word: raw=%h data=%h want 1AA/FE", raw_word, data_out); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL slip_still_locked: got %b want 1", locked); end
    send_bits(TOK00, 10);
    tests_run++; if (locked !== 1'b0 || se_cnt != 0) begin tests_failed++; $display("FAIL slip_drop: locked=%b se=%0d want 0/0", locked, se_cnt); end
    for (int k = 0; k < 3; k++) begin
      send_bits(TOK00, 10);
      tests_run++; if (locked !== (k == 2)) begin tests_failed++; $display("FAIL slip_relock%0d: got %b want %b", k, locked, k == 2); end
    end
    send_bits(TOK00, 10);
    tests_run++; if (wv_cnt != 1 || raw_word !== TOK00 || de !== 1'b0) begin tests_failed++; $display("FAIL slip_newphase: wv=%0d raw=%h de=%b want 1/%h/0", wv_cnt, raw_word, de, TOK00); end
  endtask

  task automatic test_midreset;
    send_bits(TOK00, 5);
    #2 n_rst = 1'b0;
    #1;
    tests_run++; if (locked !== 1'b0 || word_valid !== 1'b0 || sym_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags: locked=%b wv=%b se=%b want 0/0/0", locked, word_valid, sym_err); end
    tests_run++; if (raw_word !== 10'h000 || data_out !== 8'h00 || ctrl_out !== 2'b00 || de !== 1'b0) begin tests_failed++; $display("FAIL midrst_data: raw=%h data=%h ctrl=%b de=%b want 0", raw_word, data_out, ctrl_out, de); end
    @(posedge clk);
    @(posedge clk);
    #3 n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_bits(TOK00, 10);
      tests_run++; if (locked !== (k == 3)) begin tests_failed++; $display("FAIL midrst_relock%0d: got %b want %b", k, locked, k == 3); end
    end
  endtask

  initial begin
    wv_cnt = 0;
    se_cnt = 0;
    test_reset;
    test_lock;
    test_data;
    test_ctrl;
    test_errors;
    test_slip;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
